// File: rtl/ea_sequencer_if.sv
// Decoder-request and memory-port signals of the effective-address sequencer.
// master = sequencer side, slave = decoder/memory side.
interface ea_sequencer_if;
  logic        start;
  logic [11:0] ir;
  logic [11:0] pclatched;
  logic        dir;
  logic        ind;
  logic        ppind;
  logic        mp;
  logic        mreq;
  logic        mwe;
  logic [11:0] maddr;
  logic [11:0] mdout;
  logic [11:0] mdin;
  logic        mack;
  logic [11:0] ea;
  logic        eavalid;
  logic        busy;
  logic        err;

  // mreq/mack: mreq is held with maddr/mwe/mdout stable until mack is sampled
  // high on a rising edge; mack is ignored while mreq is low.
  modport master (
    input  start, ir, pclatched, dir, ind, ppind, mp, mdin, mack,
    output mreq, mwe, maddr, mdout, ea, eavalid, busy, err
  );

  modport slave (
    output start, ir, pclatched, dir, ind, ppind, mp, mdin, mack,
    input  mreq, mwe, maddr, mdout, ea, eavalid, busy, err
  );
endinterface

// File: rtl/ea_sequencer.sv
// Effective-address sequencer: direct, indirect and auto-index operand addresses.
// Define AUTOINDEX_EN to make PPIND read-increment-write the pointer; otherwise PPIND acts as IND.
module ea_sequencer #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ea_sequencer_if.master        bus,
  output logic [1:0]            state_dbg
);

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT_M1 = CW'(WAIT_LIMIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RDPTR = 2'd1, WRPTR = 2'd2, DONE = 2'd3} state_t;

  state_t          state_q, state_d;
  logic            mreq_q, mreq_d;
  logic            mwe_q, mwe_d;
  logic [11:0]     maddr_q, maddr_d;
  logic [11:0]     mdout_q, mdout_d;
  logic [11:0]     ea_q, ea_d;
  logic            eavalid_q, eavalid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [11:0]     pa;
  logic            timeout;
  logic            unused_inputs;
`ifdef AUTOINDEX_EN
  logic            ai_q, ai_d;
`endif

  assign pa      = bus.mp ? {bus.pclatched[11:7], bus.ir[6:0]} : {5'b0, bus.ir[6:0]};
  assign timeout = (WAIT_LIMIT != 0) && mreq_q && !bus.mack && (wcnt_q == LIMIT_M1);
  // No mode flag set is handled as direct, so DIR itself carries no extra information.
  assign unused_inputs = ^{bus.dir, bus.ir[11:7], bus.pclatched[6:0]};

  always_comb begin
    state_d   = state_q;
    mreq_d    = mreq_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    mdout_d   = mdout_q;
    ea_d      = ea_q;
    eavalid_d = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    wcnt_d    = wcnt_q;
`ifdef AUTOINDEX_EN
    ai_d      = ai_q;
`endif
    case (state_q)
      IDLE: begin
        // busy still covers the EAVALID/ERR cycle, which blocks a START there.
        if (eavalid_q || err_q) busy_d = 1'b0;
        if (bus.start && !busy_q) begin
          busy_d = 1'b1;
          if (bus.ppind || bus.ind) begin
            maddr_d = pa;
            mwe_d   = 1'b0;
            mreq_d  = 1'b1;
            wcnt_d  = '0;
            state_d = RDPTR;
`ifdef AUTOINDEX_EN
            ai_d    = bus.ppind;
`endif
          end else begin
            ea_d    = pa;
            state_d = DONE;
          end
        end
      end
      RDPTR: begin
        if (bus.mack) begin
          mreq_d = 1'b0;
          wcnt_d = '0;
`ifdef AUTOINDEX_EN
          if (ai_q) begin
            mdout_d = bus.mdin + 12'd1;
            state_d = WRPTR;
          end else begin
            ea_d    = bus.mdin;
            state_d = DONE;
          end
`else
          ea_d    = bus.mdin;
          state_d = DONE;
`endif
        end else if (timeout) begin
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          err_d   = 1'b1;
          wcnt_d  = '0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
`ifdef AUTOINDEX_EN
      WRPTR: begin
        // First cycle here is the one-cycle mreq gap between the read and the write.
        // EA only takes the incremented pointer once the write-back lands.
        if (!mreq_q) begin
          mreq_d = 1'b1;
          mwe_d  = 1'b1;
          wcnt_d = '0;
        end else if (bus.mack) begin
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          ea_d    = mdout_q;
          wcnt_d  = '0;
          state_d = DONE;
        end else if (timeout) begin
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          err_d   = 1'b1;
          wcnt_d  = '0;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + CW'(1);
        end
      end
`endif
      DONE: begin
        eavalid_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mreq_q    <= 1'b0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
      mdout_q   <= '0;
      ea_q      <= '0;
      eavalid_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      wcnt_q    <= '0;
`ifdef AUTOINDEX_EN
      ai_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mreq_q    <= mreq_d;
      mwe_q     <= mwe_d;
      maddr_q   <= maddr_d;
      mdout_q   <= mdout_d;
      ea_q      <= ea_d;
      eavalid_q <= eavalid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      wcnt_q    <= wcnt_d;
`ifdef AUTOINDEX_EN
      ai_q      <= ai_d;
`endif
    end
  end

  assign bus.mreq    = mreq_q;
  assign bus.mwe     = mwe_q;
  assign bus.maddr   = maddr_q;
  assign bus.mdout   = mdout_q;
  assign bus.ea      = ea_q;
  assign bus.eavalid = eavalid_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ea_sequencer.sv
// Directed bench for ea_sequencer with a memory responder of programmable wait.
// Expectations follow AUTOINDEX_EN when it is defined for the build.
module tb_ea_sequencer;

  logic clk;
  logic rst;
  logic [1:0] state_dbg;

  ea_sequencer_if bus();

  ea_sequencer #(.WAIT_LIMIT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [11:0] mem [0:4095];
  int  wait_cycles = 0;
  bit  resp_en     = 1'b1;
  int  wcnt_tb     = 0;
  int  rd_count    = 0;
  int  wr_count    = 0;
  logic [11:0] last_rd_addr = '0;
  logic [11:0] last_wr_addr = '0;
  logic [11:0] last_wr_data = '0;

  // Memory responder: acks after wait_cycles idle mreq cycles
  always @(negedge clk) begin
    if (resp_en && bus.mreq && !bus.mack) begin
      if (wcnt_tb == wait_cycles) begin
        bus.mack = 1'b1;
        bus.mdin = mem[bus.maddr];
        if (bus.mwe) begin
          mem[bus.maddr] = bus.mdout;
          last_wr_addr = bus.maddr;
          last_wr_data = bus.mdout;
          wr_count++;
        end else begin
          last_rd_addr = bus.maddr;
          rd_count++;
        end
        wcnt_tb = 0;
      end else begin
        bus.mack = 1'b0;
        wcnt_tb++;
      end
    end else begin
      bus.mack = 1'b0;
      wcnt_tb  = 0;
    end
  end

  int mreq_cyc = 0, mwe_cyc = 0, mreq_rise = 0, ev_cyc = 0, err_cyc = 0;
  logic mreq_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.mreq) mreq_cyc++;
    if (bus.mreq && bus.mwe) mwe_cyc++;
    if (bus.mreq && !mreq_prev) mreq_rise++;
    mreq_prev = bus.mreq;
    if (bus.eavalid) ev_cyc++;
    if (bus.err) err_cyc++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no_finish required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0o required %0o (octal)", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [11:0] ir_v, input logic [11:0] pc_v,
                       input logic d, input logic i, input logic p, input logic m);
    bus.ir = ir_v; bus.pclatched = pc_v;
    bus.dir = d; bus.ind = i; bus.ppind = p; bus.mp = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.dir = 1'b0; bus.ind = 1'b0; bus.ppind = 1'b0; bus.mp = 1'b0;
  endtask

  // Cycle index (accept edge = cycle 1) at which eavalid or err is seen.
  task automatic wait_done(output int lat, output bit ev, output bit er);
    lat = 0; ev = 1'b0; er = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (!ev && !er) begin
        if (bus.eavalid || bus.err) begin
          ev = bus.eavalid; er = bus.err; lat = k;
        end else begin
          step();
        end
      end
    end
  endtask

  int lat;
  bit ev, er;
  int s_mreq, s_mwe, s_rise, s_ev, s_err, s_rd, s_wr;
  bit found;

  task automatic snap();
    s_mreq = mreq_cyc; s_mwe = mwe_cyc; s_rise = mreq_rise;
    s_ev = ev_cyc; s_err = err_cyc; s_rd = rd_count; s_wr = wr_count;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.ir = '0; bus.pclatched = '0;
    bus.dir = 1'b0; bus.ind = 1'b0; bus.ppind = 1'b0; bus.mp = 1'b0;
    for (int a = 0; a < 4096; a++) mem[a] = 12'(a) ^ 12'o5252;
    mem[12'o0050] = 12'o3456;
    mem[12'o0010] = 12'o7777;
    mem[12'o0011] = 12'o0123;
    mem[12'o0012] = 12'o0100;

    // Reset state
    step(); step();
    chk("rst_mreq", bus.mreq, 0);
    chk("rst_mwe", bus.mwe, 0);
    chk("rst_eavalid", bus.eavalid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ea", bus.ea, 0);
    chk("rst_maddr", bus.maddr, 0);
    chk("rst_mdout", bus.mdout, 0);
    chk("rst_state", state_dbg, 0);
    rst = 1'b0;
    step();

    // Direct, current page
    snap();
    issue(12'o1234, 12'o4200, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("t1_busy_c1", bus.busy, 1);
    chk("t1_eavalid_c1", bus.eavalid, 0);
    wait_done(lat, ev, er);
    chk("t1_latency", lat, 2);
    chk("t1_ev", ev, 1);
    chk("t1_ea", bus.ea, 12'o4234);
    chk("t1_busy_ev", bus.busy, 1);
    step();
    chk("t1_ev_pulse", bus.eavalid, 0);
    chk("t1_busy_end", bus.busy, 0);
    chk("t1_no_mreq", mreq_cyc - s_mreq, 0);
    chk("t1_ev_count", ev_cyc - s_ev, 1);

    // Direct, page zero
    issue(12'o3177, 12'o4200, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(lat, ev, er);
    chk("t2_latency", lat, 2);
    chk("t2_ea", bus.ea, 12'o0177);
    step();
    chk("t2_busy_end", bus.busy, 0);

    // No mode flag: handled as direct
    snap();
    issue(12'o6777, 12'o2000, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_done(lat, ev, er);
    chk("t2b_latency", lat, 2);
    chk("t2b_ea", bus.ea, 12'o2177);
    step();
    chk("t2b_no_mreq", mreq_cyc - s_mreq, 0);

    // Indirect, 3 wait cycles
    snap();
    wait_cycles = 3;
    issue(12'o1450, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_mreq_c1", bus.mreq, 1);
    chk("t3_maddr", bus.maddr, 12'o0050);
    wait_done(lat, ev, er);
    chk("t3_latency", lat, 6);
    chk("t3_ea", bus.ea, 12'o3456);
    step();
    chk("t3_reads", rd_count - s_rd, 1);
    chk("t3_writes", wr_count - s_wr, 0);
    chk("t3_rd_addr", last_rd_addr, 12'o0050);
    chk("t3_mwe_cycles", mwe_cyc - s_mwe, 0);
    chk("t3_mreq_cycles", mreq_cyc - s_mreq, 4);

    // Auto-index with wrap, zero wait
    snap();
    wait_cycles = 0;
    issue(12'o1410, 12'o0000, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(lat, ev, er);
`ifdef AUTOINDEX_EN
    chk("t4_latency", lat, 5);
    chk("t4_ea", bus.ea, 12'o0000);
    step();
    chk("t4_writes", wr_count - s_wr, 1);
    chk("t4_wr_addr", last_wr_addr, 12'o0010);
    chk("t4_wr_data", last_wr_data, 12'o0000);
    chk("t4_mem", mem[12'o0010], 12'o0000);
    chk("t4_mreq_rises", mreq_rise - s_rise, 2);
`else
    chk("t4_latency", lat, 3);
    chk("t4_ea", bus.ea, 12'o7777);
    step();
    chk("t4_writes", wr_count - s_wr, 0);
    chk("t4_mwe_cycles", mwe_cyc - s_mwe, 0);
    chk("t4_mem", mem[12'o0010], 12'o7777);
`endif

    // Auto-index without wrap, 2 wait cycles per access
    snap();
    wait_cycles = 2;
    issue(12'o0011, 12'o0000, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(lat, ev, er);
`ifdef AUTOINDEX_EN
    chk("t4b_latency", lat, 9);
    chk("t4b_ea", bus.ea, 12'o0124);
    step();
    chk("t4b_mem", mem[12'o0011], 12'o0124);
`else
    chk("t4b_latency", lat, 5);
    chk("t4b_ea", bus.ea, 12'o0123);
    step();
    chk("t4b_mem", mem[12'o0011], 12'o0123);
`endif

    // Timeout: no ack ever
    snap();
    resp_en = 1'b0;
    issue(12'o1460, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_done(lat, ev, er);
    chk("t5_err_seen", er, 1);
    chk("t5_no_eavalid", ev, 0);
    chk("t5_err_latency", lat, 5);
    chk("t5_mreq_low", bus.mreq, 0);
`ifdef AUTOINDEX_EN
    chk("t5_ea_kept", bus.ea, 12'o0124);
`else
    chk("t5_ea_kept", bus.ea, 12'o0123);
`endif
    step();
    chk("t5_err_pulse", bus.err, 0);
    chk("t5_busy_end", bus.busy, 0);
    chk("t5_mreq_cycles", mreq_cyc - s_mreq, 4);
    chk("t5_err_count", err_cyc - s_err, 1);
    chk("t5_ev_count", ev_cyc - s_ev, 0);
    resp_en = 1'b1;
    issue(12'o0005, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(lat, ev, er);
    chk("t5_next_latency", lat, 2);
    chk("t5_next_ea", bus.ea, 12'o0005);
    step();

    // START while busy is ignored
    snap();
    wait_cycles = 2;
    issue(12'o0050, 12'o0000, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.ir = 12'o0077; bus.dir = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.dir = 1'b0;
    wait_done(lat, ev, er);
    chk("t6_ev", ev, 1);
    chk("t6_ea", bus.ea, 12'o3456);
    step();
    step();
    chk("t6_ev_count", ev_cyc - s_ev, 1);
    chk("t6_reads", rd_count - s_rd, 1);

    // Reset in the middle of the pointer access
    snap();
    wait_cycles = 5;
    found = 1'b0;
`ifdef AUTOINDEX_EN
    issue(12'o0012, 12'o0000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) if (!found) begin
      if (bus.mreq && bus.mwe) found = 1'b1; else step();
    end
    chk("t7_in_write", found, 1);
    chk("t7_state_wr", state_dbg, 2);
`else
    issue(12'o0012, 12'o0000, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 30; k++) if (!found) begin
      if (bus.mreq) found = 1'b1; else step();
    end
    chk("t7_in_read", found, 1);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t7_mreq", bus.mreq, 0);
    chk("t7_mwe", bus.mwe, 0);
    chk("t7_state", state_dbg, 0);
    chk("t7_busy", bus.busy, 0);
    chk("t7_ea", bus.ea, 0);
    step();
    rst = 1'b0;
    step(); step();
    chk("t7_no_write", wr_count - s_wr, 0);
    chk("t7_mem", mem[12'o0012], 12'o0100);
    wait_cycles = 0;
    issue(12'o0123, 12'o0000, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(lat, ev, er);
    chk("t7_recover_latency", lat, 2);
    chk("t7_recover_ea", bus.ea, 12'o0123);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ea_sequencer.md
Name: ea_sequencer

Overview:
- Effective-address sequencer directly downstream of the instruction decoder.
- Consumes the latched IR and PC plus the decoder's addressing-mode flags (DIR, IND, PPIND, MP).
- Produces the final 12-bit operand address for memory-reference instructions:
  - direct: computes the address combinationally-registered;
  - indirect: fetches the pointer from memory;
  - auto-index (locations 0010-0017, indirect): reads the pointer, increments it, writes it back and uses the incremented value.
- Shares the memory port through a simple req/ack handshake.

Parameters:
- WAIT_LIMIT, 255: maximum cycles to wait for MACK on any access before abort; 0 = wait forever.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request; IR/PCLATCHED/mode flags valid in the same cycle
- IR  in  12  instruction register
- PCLATCHED  in  12  PC of current instruction
- DIR  in  1  direct mode (from decoder)
- IND  in  1  indirect mode
- PPIND  in  1  auto-index indirect mode
- MP  in  1  current-page bit
- MREQ  out  1  memory access request
- MWE  out  1  write enable qualifying MREQ
- MADDR  out  12  memory address
- MDOUT  out  12  write data
- MDIN  in  12  read data, valid when MACK=1
- MACK  in  1  access complete
- EA  out  12  effective address, held until next START
- EAVALID  out  1  one-cycle pulse, EA valid
- BUSY  out  1  high from cycle after accepted START until EAVALID/ERR cycle inclusive
- ERR  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset, asynchronous: state IDLE; MREQ, MWE, EAVALID, BUSY and ERR forced 0 immediately; EA, MADDR, MDOUT = 0; wait counter = 0.
- Page address PA is computed from the inputs sampled at START:
  - MP=1: PA = {PCLATCHED[11:7], IR[6:0]};
  - MP=0: PA = {5'b0, IR[6:0]}.
- Mode priority: PPIND > IND > DIR. If no flag is set (IOT/OPR with IR[8]=1), treat as direct.
- States: IDLE, RDPTR, WRPTR, DONE.
- IDLE:
  - START=1 captures PA.
  - Direct: EA<=PA, go to DONE.
  - IND/PPIND: MADDR<=PA, MWE<=0, MREQ<=1, go to RDPTR.
  - START=0: stay in IDLE.
- RDPTR: hold MREQ/MADDR until MACK=1, then MREQ<=0.
  - IND: EA<=MDIN, go to DONE.
  - PPIND: EA<=MDIN+1 (mod 4096, 7777 wraps to 0000); MDOUT<=MDIN+1, MWE<=1, MREQ<=1, MADDR unchanged; go to WRPTR.
- WRPTR: hold MREQ/MWE/MADDR/MDOUT until MACK=1, then MREQ<=0, MWE<=0, go to DONE.
- DONE: EAVALID=1 for exactly one cycle, BUSY=1, return to IDLE.
- Latency from START edge to EAVALID:
  - direct: 2 cycles;
  - indirect: 2 + read wait;
  - auto-index: 3 + read wait + write wait.
  - A zero-wait ack (MACK high in the first MREQ cycle) counts 1 cycle.
- MREQ drops in the cycle after MACK is sampled. Back-to-back read and write are separated by exactly one cycle of MREQ=0.
- START while BUSY or in DONE is ignored (no queueing). A new START in IDLE may be accepted the cycle after EAVALID.
- MACK while MREQ=0 is ignored.
- Timeout (WAIT_LIMIT>0): the counter clears on each MREQ rise and increments each cycle MREQ=1 and MACK=0. On reaching WAIT_LIMIT:
  - MREQ<=0, MWE<=0;
  - ERR pulses 1 cycle, no EAVALID;
  - EA keeps its previous value;
  - go to IDLE.
- Reset mid-operation abandons any access; a pending write is not completed.

Optional Feature:
- Macro AUTOINDEX_EN.
- Defined: PPIND performs read-increment-write as above.
- Undefined: PPIND is treated exactly like IND (read only, EA=MDIN, no WRPTR state, MWE never asserted). The WRPTR logic and incrementer are not synthesised.

Test Plan:
- Direct current page: IR=0o1234, PCLATCHED=0o4200, MP=1, DIR=1, START -> EAVALID two cycles later, EA=0o4234, MREQ never asserted.
- Direct page zero: IR=0o3177, MP=0, DIR=1 -> EA=0o0177, EAVALID pulse, BUSY then low.
- Indirect: IR=0o1450, IND=1, mem[0o0050]=0o3456, MACK after 3 wait cycles -> single read MADDR=0o0050, MWE=0 throughout, EA=0o3456.
- Auto-index wrap (AUTOINDEX_EN): IR=0o1410, PPIND=1, mem[0o0010]=0o7777 -> read 0o0010, write MDOUT=0o0000 to 0o0010, EA=0o0000; without the macro: no write, EA=0o7777.
- Timeout: WAIT_LIMIT=4, IND access, MACK held 0 -> MREQ drops after 4 cycles, ERR one-cycle pulse, no EAVALID, EA unchanged, next START accepted normally.
- Reset/overlap: assert RESET during WRPTR -> MREQ/MWE low immediately, state IDLE. START pulsed while BUSY -> ignored, EA reflects only the first request.
